// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues sized req/ack bus transactions, extends load data,
// and holds the pipeline until the bus acknowledges or the wait counter expires.
module mem_access_unit #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_ALU_out,
    input  logic [31:0] mem_DataB,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [31:0] mem_load_data,
    output logic        stall_req,
    output logic        lsu_misalign,
    output logic        lsu_timeout
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_q, ld_d;
    logic        tmo_q, tmo_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;

    logic        op_active;
    logic        is_store;
    logic        is_load;
    logic [1:0]  lane;
    size_t       size;
    logic        misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // A store wins when both read and write are flagged.
    assign op_active = mem_read | mem_write;
    assign is_store  = mem_write;
    assign is_load   = mem_read & ~mem_write;
    assign lane      = mem_ALU_out[1:0];

    always_comb begin
        size = SZ_WORD;
        if (is_store) begin
            case (mem_funct3)
                3'b000:  size = SZ_BYTE;
                3'b001:  size = SZ_HALF;
                default: size = SZ_WORD;
            endcase
        end else begin
            case (mem_funct3)
                3'b000, 3'b100: size = SZ_BYTE;
                3'b001, 3'b101: size = SZ_HALF;
                default:        size = SZ_WORD;
            endcase
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = |lane;
            default: misaligned = 1'b0;
        endcase
    end

    // Stores replicate the datum across all lanes; loads always fetch the full word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = '0;
        if (is_store) begin
            case (size)
                SZ_BYTE: begin
                    st_be    = 4'b0001 << lane;
                    st_wdata = {4{mem_DataB[7:0]}};
                end
                SZ_HALF: begin
                    st_be    = 4'b0011 << {lane[1], 1'b0};
                    st_wdata = {2{mem_DataB[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = mem_DataB;
                end
            endcase
        end
    end

    assign ld_byte = dbus_rdata[{lane_q, 3'b000} +: 8];
    assign ld_half = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'b0, ld_byte};
            3'b101:  ld_ext = {16'b0, ld_half};
            default: ld_ext = dbus_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every next-state value is defaulted first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        tmo_d   = 1'b0;
        f3_d    = f3_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (op_active) begin
                    if (misaligned) begin
                        if (is_load) ld_d = '0;
                    end else begin
                        state_d = BUS;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {mem_ALU_out[31:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        cnt_d   = '0;
                        f3_d    = mem_funct3;
                        lane_d  = lane;
                    end
                end
            end
            BUS: begin
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) ld_d = ld_ext;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                    if (!we_q) ld_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            tmo_q   <= 1'b0;
            f3_q    <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            tmo_q   <= tmo_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
        end
    end

    assign dbus_req      = req_q;
    assign dbus_we       = we_q;
    assign dbus_addr     = addr_q;
    assign dbus_be       = be_q;
    assign dbus_wdata    = wdata_q;
    assign mem_load_data = ld_q;
    assign lsu_timeout   = tmo_q;

    // Combinational flags are gated by reset so they drop together with the registers.
    assign stall_req    = rst_n & ((state_q == BUS) ||
                                   (state_q == IDLE && op_active && !misaligned));
    assign lsu_misalign = rst_n & (state_q == IDLE) & op_active & misaligned;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset-in-flight sequence, and
// randomized ops checked against an arithmetic model of the load/store rules.
module tb_mem_access_unit;

    localparam int WAIT_MAX = 4;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] rdat;
        int          dly;
        bit          exp_mis;
        bit          exp_tmo;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_ALU_out, mem_DataB;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata, dbus_rdata;
    logic        dbus_ack;
    logic [31:0] mem_load_data;
    logic        stall_req, lsu_misalign, lsu_timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ld_now = '0;

    mem_access_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_ALU_out(mem_ALU_out), .mem_DataB(mem_DataB),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .mem_load_data(mem_load_data), .stall_req(stall_req),
        .lsu_misalign(lsu_misalign), .lsu_timeout(lsu_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_read = 1'b0; mem_write = 1'b0; mem_funct3 = '0;
        mem_ALU_out = '0; mem_DataB = '0; dbus_ack = 1'b0; dbus_rdata = '0;
    endtask

    // Reference model: derives sizing, lanes and extension from byte arithmetic.
    function automatic vec_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic [31:0] r, input int dly,
                                   input logic [31:0] prev);
        vec_t v;
        int size, off;
        bit load;
        longint unsigned mask, val, rep;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.din = d; v.rdat = r; v.dly = dly;
        load = rd && !wr;
        off  = int'(a % 4);
        if (wr) size = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        else    size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
        v.exp_mis = (rd || wr) && (off % size != 0);
        v.exp_tmo = (rd || wr) && !v.exp_mis && dly >= WAIT_MAX;
        if (!wr || size == 4) v.exp_be = 4'hF;
        else                  v.exp_be = 4'(((1 << size) - 1) << off);
        mask = (64'd1 << (8 * size)) - 1;
        rep  = (size == 1) ? 64'h01010101 : (size == 2) ? 64'h00010001 : 64'h1;
        v.exp_wd = 32'((64'(d) & mask) * rep);
        v.exp_ld = prev;
        if (load && (v.exp_mis || v.exp_tmo)) begin
            v.exp_ld = '0;
        end else if (load) begin
            val = (64'(r) >> (8 * off)) & mask;
            if (size < 4 && f3[2] == 1'b0 && val >= (mask + 1) / 2) val = val | ~mask;
            v.exp_ld = 32'(val);
        end
        return v;
    endfunction

    // Starts at posedge+1 in IDLE and returns at posedge+1 of the following IDLE cycle.
    task automatic run_op(input vec_t v, input string tag);
        logic [31:0] exp_addr;
        int k, stall_n;
        bit fin, is_op;
        is_op    = v.rd || v.wr;
        exp_addr = v.addr & 32'hFFFF_FFFC;
        mem_read = v.rd; mem_write = v.wr; mem_funct3 = v.f3;
        mem_ALU_out = v.addr; mem_DataB = v.din; dbus_ack = 1'b0;
        #3;
        check({tag, " idle_req"},  32'(dbus_req), 32'd0);
        check({tag, " tmo_clear"}, 32'(lsu_timeout), 32'd0);
        check({tag, " ld_hold"},   mem_load_data, exp_ld_now);
        check({tag, " misalign"},  32'(lsu_misalign), 32'(v.exp_mis));
        check({tag, " stall_idle"}, 32'(stall_req), 32'(is_op && !v.exp_mis));
        @(posedge clk); #1;
        if (!is_op || v.exp_mis) begin
            exp_ld_now = v.exp_ld;
            clear_inputs();
            return;
        end
        stall_n = 1;
        k = 0;
        fin = 1'b0;
        while (!fin) begin
            dbus_ack   = (k == v.dly);
            dbus_rdata = v.rdat;
            #3;
            check({tag, " bus_req"},   32'(dbus_req), 32'd1);
            check({tag, " bus_stall"}, 32'(stall_req), 32'd1);
            check({tag, " bus_addr"},  dbus_addr, exp_addr);
            check({tag, " bus_we"},    32'(dbus_we), 32'(v.wr));
            check({tag, " bus_be"},    32'(dbus_be), 32'(v.exp_be));
            if (v.wr) check({tag, " bus_wdata"}, dbus_wdata, v.exp_wd);
            if (stall_req) stall_n++;
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            if (k == v.dly || k == WAIT_MAX - 1) fin = 1'b1;
            k++;
        end
        if (v.exp_tmo) begin
            dbus_ack   = 1'b1;
            dbus_rdata = 32'hFFFF_FFFF;
        end
        #3;
        check({tag, " done_stall"}, 32'(stall_req), 32'd0);
        check({tag, " done_req"},   32'(dbus_req), 32'd0);
        check({tag, " done_tmo"},   32'(lsu_timeout), 32'(v.exp_tmo));
        check({tag, " done_ld"},    mem_load_data, v.exp_ld);
        check({tag, " stall_cycles"}, 32'(stall_n),
              32'(1 + (v.exp_tmo ? WAIT_MAX : v.dly + 1)));
        @(posedge clk); #1;
        exp_ld_now = v.exp_ld;
        clear_inputs();
    endtask

    function automatic vec_t tv(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] r, input int dly, input bit mis,
                                input bit tmo, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] ld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.din = d; v.rdat = r; v.dly = dly;
        v.exp_mis = mis; v.exp_tmo = tmo; v.exp_be = be; v.exp_wd = wd; v.exp_ld = ld;
        return v;
    endfunction

    initial begin
        vec_t tab[15];
        vec_t v;
        int sel;
        bit rd, wr;

        tab[0]  = tv(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 2, 0, 0, 4'hF, 0, 32'hDEADBEEF);
        tab[1]  = tv(1, 0, 3'b000, 32'h203, 0, 32'h80FFFFFF, 0, 0, 0, 4'hF, 0, 32'hFFFFFF80);
        tab[2]  = tv(1, 0, 3'b100, 32'h203, 0, 32'h80FFFFFF, 0, 0, 0, 4'hF, 0, 32'h00000080);
        tab[3]  = tv(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h00000080);
        tab[4]  = tv(1, 0, 3'b010, 32'h101, 0, 0, 0, 1, 0, 4'hF, 0, 32'h0);
        tab[5]  = tv(1, 0, 3'b001, 32'h202, 0, 32'h80017FFF, 1, 0, 0, 4'hF, 0, 32'hFFFF8001);
        tab[6]  = tv(1, 0, 3'b101, 32'h200, 0, 32'h8001F00F, 3, 0, 0, 4'hF, 0, 32'h0000F00F);
        tab[7]  = tv(0, 1, 3'b000, 32'h7, 32'h55, 0, 3, 0, 0, 4'b1000, 32'h55555555, 32'h0000F00F);
        tab[8]  = tv(1, 0, 3'b010, 32'h300, 0, 32'h11111111, 99, 0, 1, 4'hF, 0, 32'h0);
        tab[9]  = tv(1, 1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 0, 0, 0, 4'hF, 32'hCAFEF00D, 32'h0);
        tab[10] = tv(0, 1, 3'b001, 32'h103, 32'h7777, 0, 0, 1, 0, 4'hF, 0, 32'h0);
        tab[11] = tv(0, 0, 3'b000, 32'h0, 0, 0, 0, 0, 0, 4'hF, 0, 32'h0);
        tab[12] = tv(0, 1, 3'b011, 32'h20, 32'h0BADBEEF, 0, 1, 0, 0, 4'hF, 32'h0BADBEEF, 32'h0);
        tab[13] = tv(1, 0, 3'b111, 32'h24, 0, 32'h12345678, 0, 0, 0, 4'hF, 0, 32'h12345678);
        tab[14] = tv(1, 0, 3'b000, 32'h1, 0, 32'h00007F00, 0, 0, 0, 4'hF, 0, 32'h0000007F);

        clear_inputs();
        rst_n = 1'b0;
        mem_read = 1'b1;
        #2;
        check("rst stall", 32'(stall_req), 32'd0);
        check("rst req",   32'(dbus_req), 32'd0);
        check("rst ld",    mem_load_data, 32'd0);
        check("rst be",    32'(dbus_be), 32'd0);
        mem_read = 1'b0;
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tab[i]) run_op(tab[i], $sformatf("vec%0d", i));

        // Reset asserted mid-BUS, with an ack arriving while reset is held.
        mem_read = 1'b1; mem_funct3 = 3'b010; mem_ALU_out = 32'h40;
        @(posedge clk); #1;
        #3;
        check("rstbus req_before", 32'(dbus_req), 32'd1);
        #1;
        rst_n = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = 32'hA5A5A5A5;
        #1;
        check("rstbus req_drop",   32'(dbus_req), 32'd0);
        check("rstbus stall_drop", 32'(stall_req), 32'd0);
        check("rstbus addr",       dbus_addr, 32'd0);
        check("rstbus ld",         mem_load_data, 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_ld_now = '0;
        run_op(model(1, 0, 3'b010, 32'h80, 0, 32'h5A5A1234, 1, exp_ld_now), "post_rst");

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            rd = (sel >= 1 && sel <= 5);
            wr = (sel == 1 || sel >= 6);
            v = model(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      wr ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 5)),
                      exp_ld_now);
            run_op(v, $sformatf("rnd%0d", n));
        end

        run_op(model(0, 0, 3'b000, 0, 0, 0, 0, exp_ld_now), "final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
